// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants and state type for the mux channel scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } scan_state_t;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter16.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter16
// Description : Combinational 16-way round-robin picker starting after last grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter16
    import mux_pkg::*;
(
    input  logic [NCH-1:0]   i_pending,
    input  logic [SEL_W-1:0] i_last_grant,
    output logic [SEL_W-1:0] o_grant,
    output logic             o_valid
);

    logic [SEL_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_idx = i_last_grant + SEL_W'(i);
            if (i_pending[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule : rr_arbiter16
`default_nettype wire

// File: rtl/mux_channel_scanner.sv
`default_nettype none
// ============================================================================
// Module      : mux_channel_scanner
// Description : Scans requesting channels through an external 16:1 mux and
//               hands each captured word to a valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_channel_scanner
    import mux_pkg::*;
#(
    parameter int DW      = 8,
    parameter int MUX_LAT = 0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    output logic [SEL_W-1:0] sel,
    input  logic [DW-1:0]    mux_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [SEL_W-1:0] m_chan,
    output logic [NCH-1:0]   pending,
    output logic             busy
);

    scan_state_t      r_state;
    scan_state_t      w_next_state;
    logic [NCH-1:0]   r_pending;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_last;
    logic [1:0]       r_cnt;
    logic             r_valid;
    logic [DW-1:0]    r_data;
    logic [SEL_W-1:0] r_chan;

    logic [SEL_W-1:0] w_grant_idx;
    logic             w_any;
    logic             w_do_grant;
    logic             w_capture;
    logic             w_handshake;
    logic [NCH-1:0]   w_grant_mask;

    rr_arbiter16 u_arb (
        .i_pending    (r_pending),
        .i_last_grant (r_last),
        .o_grant      (w_grant_idx),
        .o_valid      (w_any)
    );

    assign w_handshake  = (r_state == ST_HOLD) && r_valid && m_ready;
    assign w_grant_mask = w_do_grant ? ({{(NCH-1){1'b0}}, 1'b1} << w_grant_idx) : '0;

    always_comb begin
        w_next_state = r_state;
        w_do_grant   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_do_grant   = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Back-to-back grant on the handshake edge keeps 2-cycle throughput.
                if (w_handshake) begin
                    if (w_any) begin
                        w_do_grant   = 1'b1;
                        w_next_state = ST_WAIT;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_sel     <= '0;
            r_last    <= SEL_W'(NCH - 1);
            r_cnt     <= 2'd0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_chan    <= '0;
        end else begin
            r_state   <= w_next_state;
            // A new request on the grant edge re-arms the bit being cleared.
            r_pending <= (r_pending & ~w_grant_mask) | req;
            if (w_do_grant) begin
                r_sel  <= w_grant_idx;
                r_last <= w_grant_idx;
                r_cnt  <= 2'(MUX_LAT);
            end else if ((r_state == ST_WAIT) && (r_cnt != 2'd0)) begin
                r_cnt  <= r_cnt - 2'd1;
            end
            if (w_capture) begin
                r_valid <= 1'b1;
                r_data  <= mux_out;
                r_chan  <= r_sel;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sel     = r_sel;
    assign m_valid = r_valid;
    assign m_data  = r_data;
    assign m_chan  = r_chan;
    assign pending = r_pending;
    assign busy    = (r_state != ST_IDLE);

endmodule : mux_channel_scanner
`default_nettype wire
